io_2to1: RTL and testbench



---
 rtl/io_2to1.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_io_2to1.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_2to1.sv
// io_2to1: two message sources and one checking sink around a 2-to-1 node.
// Handshake inputs are debounced; errors are sticky on dbg_leds.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

module calc_redun #(
    parameter int ASZ = 4,
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);
    localparam int W = 2 * ASZ + DSZ;
    localparam int N = (W + RSZ - 1) / RSZ;

    logic [W-1:0] vec;

    // XOR-fold of the whole message in RSZ-wide chunks
    always_comb begin
        vec = {src, dst, dat};
        red = '0;
        for (int i = 0; i < N; i++) begin
            red = red ^ RSZ'(vec >> (i * RSZ));
        end
    end
endmodule

module io_deb #(
    parameter int CKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic ckd
);
    localparam int CW = $clog2(CKS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ckd <= 1'b0;
            cnt <= '0;
        end else if (raw == ckd) begin
            cnt <= '0;
        end else if (cnt == CW'(CKS - 1)) begin
            ckd <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module io_src #(
    parameter int SRC_ADDR = 9,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = 4,
    parameter int DSZ      = 8,
    parameter int RSZ      = 4,
    parameter int ACK_CKS  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ack_in,
    output logic [ASZ-1:0] src,
    output logic [ASZ-1:0] dst,
    output logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red,
    output logic           req
);
    typedef enum logic [1:0] {
        S_DST,
        S_DAT,
        S_RED,
        S_REQ
    } src_st_t;

    src_st_t        st, st_n;
    logic [ASZ-1:0] dst_n;
    logic [DSZ-1:0] dat_n;
    logic [RSZ-1:0] red_n, red_c;
    logic [3:0]     cnt, cnt_n;
    logic           req_n;
    logic           ack_ckd;

    assign src = ASZ'(SRC_ADDR);

    io_deb #(.CKS(ACK_CKS)) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (ack_in),
        .ckd  (ack_ckd)
    );

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (
        .src(src),
        .dst(dst),
        .dat(dat),
        .red(red_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= S_DST;
            dst <= ASZ'(MAX_ADDR);
            dat <= '0;
            red <= '0;
            cnt <= '0;
            req <= 1'b0;
        end else begin
            st  <= st_n;
            dst <= dst_n;
            dat <= dat_n;
            red <= red_n;
            cnt <= cnt_n;
            req <= req_n;
        end
    end

    always_comb begin
        st_n  = st;
        dst_n = dst;
        dat_n = dat;
        red_n = red;
        cnt_n = cnt;
        req_n = req;
        if (req && ack_ckd) begin
            req_n = 1'b0;
            st_n  = S_DST;
        end else if (!req && !ack_ckd) begin
            unique case (st)
                S_DST: begin
                    if (dst >= ASZ'(MAX_ADDR)) begin
                        dst_n = ASZ'(MIN_ADDR);
                    end else begin
                        dst_n = dst + ASZ'(1);
                    end
                    st_n = S_DAT;
                end
                S_DAT: begin
                    dat_n = {{(DSZ - 4){1'b0}}, cnt};
                    cnt_n = cnt + 4'd1;
                    st_n  = S_RED;
                end
                S_RED: begin
                    red_n = red_c;
                    st_n  = S_REQ;
                end
                S_REQ: begin
                    req_n = 1'b1;
                end
            endcase
        end
    end
endmodule

module io_snk #(
    parameter int SRC0_ADDR = 9,
    parameter int SRC1_ADDR = 10,
    parameter int MIN_ADDR  = 1,
    parameter int MAX_ADDR  = 1,
    parameter int ASZ       = 4,
    parameter int DSZ       = 8,
    parameter int RSZ       = 4,
    parameter int REQ_CKS   = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_in,
    input  logic [ASZ-1:0] i_src,
    input  logic [ASZ-1:0] i_dst,
    input  logic [DSZ-1:0] i_dat,
    input  logic [RSZ-1:0] i_red,
    output logic           ack,
    output logic [1:0]     seq_err,
    output logic           fmt_err,
    output logic [3:0]     disp0,
    output logic [3:0]     disp1
);
    typedef enum logic [1:0] {
        K_LAT,
        K_RED,
        K_CHK,
        K_DONE
    } snk_st_t;

    snk_st_t        st, st_n;
    logic [ASZ-1:0] l_src, l_src_n;
    logic [ASZ-1:0] l_dst, l_dst_n;
    logic [DSZ-1:0] l_dat, l_dat_n;
    logic [RSZ-1:0] l_red, l_red_n;
    logic [RSZ-1:0] c_red, c_red_n, r_c;
    logic [3:0]     back0, back0_n;
    logic [3:0]     back1, back1_n;
    logic [3:0]     disp0_n, disp1_n;
    logic [3:0]     bk, d4;
    logic [1:0]     seq_n;
    logic           fmt_n, ack_n;
    logic           req_ckd;
    logic           is0, is1, bad;

    io_deb #(.CKS(REQ_CKS)) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (req_in),
        .ckd  (req_ckd)
    );

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (
        .src(l_src),
        .dst(l_dst),
        .dat(l_dat),
        .red(r_c)
    );

    assign d4  = l_dat[3:0];
    assign is0 = (l_src == ASZ'(SRC0_ADDR));
    assign is1 = (l_src == ASZ'(SRC1_ADDR));
    assign bk  = is1 ? back1 : back0;
    assign bad = !(is0 || is1)
               || (l_dst < ASZ'(MIN_ADDR))
               || (l_dst > ASZ'(MAX_ADDR))
               || (l_red != c_red);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= K_LAT;
            l_src   <= '0;
            l_dst   <= '0;
            l_dat   <= '0;
            l_red   <= '0;
            c_red   <= '0;
            back0   <= 4'hf;
            back1   <= 4'hf;
            seq_err <= '0;
            fmt_err <= 1'b0;
            disp0   <= '0;
            disp1   <= '0;
            ack     <= 1'b0;
        end else begin
            st      <= st_n;
            l_src   <= l_src_n;
            l_dst   <= l_dst_n;
            l_dat   <= l_dat_n;
            l_red   <= l_red_n;
            c_red   <= c_red_n;
            back0   <= back0_n;
            back1   <= back1_n;
            seq_err <= seq_n;
            fmt_err <= fmt_n;
            disp0   <= disp0_n;
            disp1   <= disp1_n;
            ack     <= ack_n;
        end
    end

    always_comb begin
        st_n    = st;
        l_src_n = l_src;
        l_dst_n = l_dst;
        l_dat_n = l_dat;
        l_red_n = l_red;
        c_red_n = c_red;
        back0_n = back0;
        back1_n = back1;
        seq_n   = seq_err;
        fmt_n   = fmt_err;
        disp0_n = disp0;
        disp1_n = disp1;
        ack_n   = ack;
        if (ack && !req_ckd) begin
            ack_n = 1'b0;
        end else if (req_ckd && !ack) begin
            unique case (st)
                K_LAT: begin
                    l_src_n = i_src;
                    l_dst_n = i_dst;
                    l_dat_n = i_dat;
                    l_red_n = i_red;
                    st_n    = K_RED;
                end
                K_RED: begin
                    c_red_n = r_c;
                    st_n    = K_CHK;
                end
                K_CHK: begin
                    st_n = K_DONE;
                    if (bad) begin
                        fmt_n = 1'b1;
                    end else if (!seq_err[is1]) begin
                        // back of 15 means nothing to compare against
                        if (bk != 4'hf && bk + 4'd1 != d4) begin
                            seq_n[is1] = 1'b1;
                        end else if (is1) begin
                            back1_n = d4;
                        end else begin
                            back0_n = d4;
                        end
                    end
                end
                K_DONE: begin
                    if (is0) disp0_n = d4;
                    if (is1) disp1_n = d4;
                    ack_n = 1'b1;
                    st_n  = K_LAT;
                end
            endcase
        end
    end
endmodule

module io_2to1 #(
    parameter int MIN_ADDR  = 1,
    parameter int MAX_ADDR  = 1,
    parameter int SRC0_ADDR = 9,
    parameter int SRC1_ADDR = 10,
    parameter int ASZ       = `NS_ADDRESS_SIZE,
    parameter int DSZ       = `NS_DATA_SIZE,
    parameter int RSZ       = `NS_REDUN_SIZE,
    parameter int REQ_CKS   = `NS_REQ_CKS,
    parameter int ACK_CKS   = `NS_ACK_CKS
) (
    input  logic           clk,
    input  logic           reset,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req_out,
    input  logic           o0_ack_in,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic [RSZ-1:0] o1_red,
    output logic           o1_req_out,
    input  logic           o1_ack_in,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req_in,
    output logic           i0_ack_out,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);
    logic [1:0] seq_err;
    logic       fmt_err;

    io_src #(
        .SRC_ADDR(SRC0_ADDR), .MIN_ADDR(MIN_ADDR),
        .MAX_ADDR(MAX_ADDR), .ASZ(ASZ), .DSZ(DSZ),
        .RSZ(RSZ), .ACK_CKS(ACK_CKS)
    ) u_src0 (
        .clk   (clk),
        .reset (reset),
        .ack_in(o0_ack_in),
        .src   (o0_src),
        .dst   (o0_dst),
        .dat   (o0_dat),
        .red   (o0_red),
        .req   (o0_req_out)
    );

    io_src #(
        .SRC_ADDR(SRC1_ADDR), .MIN_ADDR(MIN_ADDR),
        .MAX_ADDR(MAX_ADDR), .ASZ(ASZ), .DSZ(DSZ),
        .RSZ(RSZ), .ACK_CKS(ACK_CKS)
    ) u_src1 (
        .clk   (clk),
        .reset (reset),
        .ack_in(o1_ack_in),
        .src   (o1_src),
        .dst   (o1_dst),
        .dat   (o1_dat),
        .red   (o1_red),
        .req   (o1_req_out)
    );

    io_snk #(
        .SRC0_ADDR(SRC0_ADDR), .SRC1_ADDR(SRC1_ADDR),
        .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR),
        .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
        .REQ_CKS(REQ_CKS)
    ) u_snk (
        .clk    (clk),
        .reset  (reset),
        .req_in (i0_req_in),
        .i_src  (i0_src),
        .i_dst  (i0_dst),
        .i_dat  (i0_dat),
        .i_red  (i0_red),
        .ack    (i0_ack_out),
        .seq_err(seq_err),
        .fmt_err(fmt_err),
        .disp0  (dbg_disp0),
        .disp1  (dbg_disp1)
    );

    assign dbg_leds = {1'b0, fmt_err, seq_err};
endmodule

// File: tb/tb_io_2to1.sv
// tb_io_2to1: drives io_2to1 as the network between sources and sink
// and checks it against a message-level reference model.

module tb_io_2to1;
    localparam int MINA = 1;
    localparam int MAXA = 3;
    localparam int S0   = 9;
    localparam int S1   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] o0_src, o0_dst, o0_red;
    logic [7:0] o0_dat;
    logic       o0_req_out, o0_ack_in;
    logic [3:0] o1_src, o1_dst, o1_red;
    logic [7:0] o1_dat;
    logic       o1_req_out, o1_ack_in;
    logic [3:0] i0_src, i0_dst, i0_red;
    logic [7:0] i0_dat;
    logic       i0_req_in, i0_ack_out;
    logic [3:0] dbg_leds, dbg_disp0, dbg_disp1;

    int ncmp = 0;
    int nfail = 0;

    int m_dst[2];
    int m_cnt[2];
    int m_back[2];
    int m_seq[2];
    int m_fmt;
    int m_disp[2];

    always #5 clk = ~clk;

    io_2to1 #(
        .MIN_ADDR(MINA), .MAX_ADDR(MAXA),
        .SRC0_ADDR(S0), .SRC1_ADDR(S1),
        .ASZ(4), .DSZ(8), .RSZ(4),
        .REQ_CKS(2), .ACK_CKS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .o0_src(o0_src), .o0_dst(o0_dst),
        .o0_dat(o0_dat), .o0_red(o0_red),
        .o0_req_out(o0_req_out), .o0_ack_in(o0_ack_in),
        .o1_src(o1_src), .o1_dst(o1_dst),
        .o1_dat(o1_dat), .o1_red(o1_red),
        .o1_req_out(o1_req_out), .o1_ack_in(o1_ack_in),
        .i0_src(i0_src), .i0_dst(i0_dst),
        .i0_dat(i0_dat), .i0_red(i0_red),
        .i0_req_in(i0_req_in), .i0_ack_out(i0_ack_out),
        .dbg_leds(dbg_leds),
        .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int redun(int s, int d, int t);
        return (s ^ d ^ (t % 16) ^ (t / 16)) % 16;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dst[k]  = MAXA;
            m_cnt[k]  = 0;
            m_back[k] = 15;
            m_seq[k]  = 0;
            m_disp[k] = 0;
        end
        m_fmt = 0;
    endtask

    task automatic model_sink(int s, int d, int t, int r);
        int k;
        if ((s != S0 && s != S1) || d < MINA || d > MAXA
            || r != redun(s, d, t)) begin
            m_fmt = 1;
        end else begin
            k = (s == S1) ? 1 : 0;
            if (m_seq[k] == 0) begin
                if (m_back[k] <= 14 && m_back[k] + 1 != t % 16)
                    m_seq[k] = 1;
                else
                    m_back[k] = t % 16;
            end
        end
        if (s == S0) m_disp[0] = t % 16;
        if (s == S1) m_disp[1] = t % 16;
    endtask

    // sel 0: o0_req_out, 1: o1_req_out, 2: i0_ack_out
    task automatic wait_lvl(input int sel, input logic v,
                            input string tag, output int n);
        logic hit;
        logic cur;
        hit = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            n++;
            cur = (sel == 0) ? o0_req_out :
                  (sel == 1) ? o1_req_out : i0_ack_out;
            hit = (cur === v);
        end
        if (!hit) begin
            ncmp++;
            nfail++;
            $error("FAIL timeout %s: observed %0b expected %0b",
                   tag, ~v, v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        o0_ack_in = 1'b0;
        o1_ack_in = 1'b0;
        i0_req_in = 1'b0;
        i0_src = '0;
        i0_dst = '0;
        i0_dat = '0;
        i0_red = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_leds"}, 32'(dbg_leds),
            32'({m_fmt[0], m_seq[1][0], m_seq[0][0]}));
        chk({tag, "_disp0"}, 32'(dbg_disp0), 32'(m_disp[0]));
        chk({tag, "_disp1"}, 32'(dbg_disp1), 32'(m_disp[1]));
    endtask

    task automatic deliver(input int k, input bit drop,
                           input bit bad_red, input int inj_dst);
        int n;
        int s, d, t, r;
        wait_lvl(k, 1'b1, "src_req", n);
        s = k ? int'(o1_src) : int'(o0_src);
        d = k ? int'(o1_dst) : int'(o0_dst);
        t = k ? int'(o1_dat) : int'(o0_dat);
        r = k ? int'(o1_red) : int'(o0_red);
        m_dst[k] = (m_dst[k] >= MAXA) ? MINA : m_dst[k] + 1;
        chk("src", 32'(s), 32'(k ? S1 : S0));
        chk("dst", 32'(d), 32'(m_dst[k]));
        chk("dat", 32'(t), 32'(m_cnt[k]));
        chk("red", 32'(r), 32'(redun(k ? S1 : S0, m_dst[k], m_cnt[k])));
        m_cnt[k] = (m_cnt[k] + 1) % 16;
        if (!drop) begin
            if (inj_dst >= 0) d = inj_dst;
            if (bad_red) r = r ^ 1;
            i0_src = 4'(s);
            i0_dst = 4'(d);
            i0_dat = 8'(t);
            i0_red = 4'(r);
            i0_req_in = 1'b1;
            wait_lvl(2, 1'b1, "snk_ack", n);
            chk("snk_ack_lat", 32'(n), 32'd6);
            model_sink(s, d, t, r);
            i0_req_in = 1'b0;
            wait_lvl(2, 1'b0, "snk_ack_fall", n);
            chk("snk_fall_lat", 32'(n), 32'd3);
            chk_state("msg");
        end
        if (k == 1) o1_ack_in = 1'b1;
        else o0_ack_in = 1'b1;
        wait_lvl(k, 1'b0, "src_req_fall", n);
        chk("src_fall_lat", 32'(n), 32'd3);
        o0_ack_in = 1'b0;
        o1_ack_in = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_req0", 32'(o0_req_out), 32'd0);
        chk("rst_req1", 32'(o1_req_out), 32'd0);
        chk("rst_ack", 32'(i0_ack_out), 32'd0);
        chk("rst_dst0", 32'(o0_dst), 32'(MAXA));
        chk("rst_dat0", 32'(o0_dat), 32'd0);
        chk("rst_red0", 32'(o0_red), 32'd0);
        chk_state("rst");
        wait_lvl(0, 1'b1, "first_req", n);
        chk("req_lat", 32'(n), 32'd4);

        for (int i = 0; i < 20; i++) deliver(0, 0, 0, -1);
        chk("loop_disp0", 32'(dbg_disp0), 32'd3);
        chk("loop_leds", 32'(dbg_leds), 32'd0);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            deliver(i % 2, 0, 0, -1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        chk("alt_disp0", 32'(dbg_disp0), 32'd3);
        chk("alt_disp1", 32'(dbg_disp1), 32'd3);
        chk("alt_leds", 32'(dbg_leds), 32'd0);

        deliver(1, 0, 0, -1);
        deliver(1, 1, 0, -1);
        deliver(1, 0, 0, -1);
        chk("drop_leds", 32'(dbg_leds), 32'b0010);

        deliver(0, 0, 1, -1);
        chk("red_fmt", 32'(dbg_leds[2]), 32'd1);

        do_reset();
        deliver(0, 0, 0, -1);
        deliver(0, 0, 0, -1);
        deliver(0, 0, 0, -1);
        deliver(0, 0, 0, -1);
        deliver(0, 0, 0, 4);
        chk("dst_fmt", 32'(dbg_leds), 32'b0100);

        wait_lvl(0, 1'b1, "pre_rst_req", n);
        #2 reset = 1'b0;
        #1;
        chk("async_req", 32'(o0_req_out), 32'd0);
        chk("async_leds", 32'(dbg_leds), 32'd0);
        chk("async_dat", 32'(o0_dat), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        deliver(0, 0, 0, -1);

        @(negedge clk);
        i0_src = 4'(S0);
        i0_dst = 4'(MINA);
        i0_dat = 8'd9;
        i0_red = 4'(redun(S0, MINA, 9));
        i0_req_in = 1'b1;
        @(negedge clk);
        i0_req_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_ack", 32'(i0_ack_out), 32'd0);
        chk_state("glitch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
